// File: rtl/riscv_pkg.sv
// Shared RV32I constants and load/store size helpers used by the MEM stage.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } acc_size_e;

    // Undefined funct3 encodings fall back to a full-word access.
    function automatic acc_size_e f3_size(input logic [2:0] f3);
        acc_size_e sz;
        case (f3)
            F3_LB, F3_LBU: sz = SZ_BYTE;
            F3_LH, F3_LHU: sz = SZ_HALF;
            default:       sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input acc_size_e sz, input logic [1:0] lane);
        logic mis;
        case (sz)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = lane[0];
            default: mis = (lane != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/data_memory.sv
// Word-organised data RAM: byte-enable synchronous write, combinational read.
module data_memory
    import riscv_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [3:0]      be_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] rdata_o
);

    logic [XLEN-1:0] mem_q [DEPTH];

    // Byte-lane write; the array deliberately has no reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/memory_cycle.sv
// MEM pipeline stage: aligns stores, extracts/extends loads, flags misaligned
// accesses and holds the MEM/WB register with flush-over-stall priority.
module memory_cycle
    import riscv_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteM,
    input  logic [1:0]      ResultSrcM,
    input  logic            MemWriteM,
    input  logic            MemReadM,
    input  logic [2:0]      funct3M,
    input  logic [4:0]      RD_M,
    input  logic [XLEN-1:0] PCPlus4M,
    input  logic [XLEN-1:0] ALU_ResultM,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic            stallW,
    input  logic            flushW,
    output logic            RegWriteW,
    output logic [1:0]      ResultSrcW,
    output logic [4:0]      RD_W,
    output logic [XLEN-1:0] PCPlus4W,
    output logic [XLEN-1:0] ALU_ResultW,
    output logic [XLEN-1:0] ReadDataW,
    output logic            MisalignW
);

    acc_size_e       size_s;
    logic [1:0]      lane_s;
    logic            bad_align_s;
    logic            misalign_s;
    logic            store_en_s;
    logic [3:0]      be_s;
    logic [XLEN-1:0] wdata_s;
    logic [XLEN-1:0] rword_s;
    logic [XLEN-1:0] load_ext_s;
    logic [7:0]      byte_s;
    logic [15:0]     half_s;

    logic            regwrite_q,  regwrite_d;
    logic [1:0]      resultsrc_q, resultsrc_d;
    logic [4:0]      rd_q,        rd_d;
    logic [XLEN-1:0] pcplus4_q,   pcplus4_d;
    logic [XLEN-1:0] alu_q,       alu_d;
    logic [XLEN-1:0] rdata_q,     rdata_d;
    logic            misalign_q,  misalign_d;

    assign size_s      = f3_size(funct3M);
    assign lane_s      = ALU_ResultM[1:0];
    assign bad_align_s = is_misaligned(size_s, lane_s);
    assign misalign_s  = bad_align_s & (MemReadM | MemWriteM);
    // Gating with rst keeps a store from landing on an edge while in reset.
    assign store_en_s  = MemWriteM & ~bad_align_s & rst;

    // Byte enables and lane-replicated store data.
    always_comb begin
        be_s    = 4'b0000;
        wdata_s = WriteDataM;
        case (size_s)
            SZ_BYTE: begin
                be_s    = 4'b0001 << lane_s;
                wdata_s = {4{WriteDataM[7:0]}};
            end
            SZ_HALF: begin
                be_s    = lane_s[1] ? 4'b1100 : 4'b0011;
                wdata_s = {2{WriteDataM[15:0]}};
            end
            default: begin
                be_s    = 4'b1111;
                wdata_s = WriteDataM;
            end
        endcase
    end

    data_memory #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_dmem (
        .clk     (clk),
        .we_i    (store_en_s),
        .be_i    (be_s),
        .addr_i  (ALU_ResultM[AW+1:2]),
        .wdata_i (wdata_s),
        .rdata_o (rword_s)
    );

    // Select the addressed byte/half and sign- or zero-extend it.
    always_comb begin
        byte_s     = rword_s[8*lane_s +: 8];
        half_s     = lane_s[1] ? rword_s[31:16] : rword_s[15:0];
        load_ext_s = rword_s;
        case (size_s)
            SZ_BYTE: begin
                if (funct3M[2]) begin
                    load_ext_s = {24'h00_0000, byte_s};
                end else begin
                    load_ext_s = {{24{byte_s[7]}}, byte_s};
                end
            end
            SZ_HALF: begin
                if (funct3M[2]) begin
                    load_ext_s = {16'h0000, half_s};
                end else begin
                    load_ext_s = {{16{half_s[15]}}, half_s};
                end
            end
            default: load_ext_s = rword_s;
        endcase
    end

    // MEM/WB next state: flush beats stall, stall holds, otherwise advance.
    always_comb begin
        regwrite_d  = regwrite_q;
        resultsrc_d = resultsrc_q;
        rd_d        = rd_q;
        pcplus4_d   = pcplus4_q;
        alu_d       = alu_q;
        rdata_d     = rdata_q;
        misalign_d  = misalign_q;
        if (flushW) begin
            regwrite_d  = 1'b0;
            resultsrc_d = RESULT_ALU;
            rd_d        = 5'd0;
            misalign_d  = 1'b0;
            pcplus4_d   = PCPlus4M;
            alu_d       = ALU_ResultM;
            rdata_d     = load_ext_s;
        end else if (!stallW) begin
            regwrite_d  = RegWriteM & ~misalign_s;
            resultsrc_d = ResultSrcM;
            rd_d        = RD_M;
            misalign_d  = misalign_s;
            pcplus4_d   = PCPlus4M;
            alu_d       = ALU_ResultM;
            rdata_d     = load_ext_s;
        end else begin
            regwrite_d  = regwrite_q;
        end
    end

    // MEM/WB register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regwrite_q  <= 1'b0;
            resultsrc_q <= 2'b00;
            rd_q        <= 5'd0;
            pcplus4_q   <= 32'h0000_0000;
            alu_q       <= 32'h0000_0000;
            rdata_q     <= 32'h0000_0000;
            misalign_q  <= 1'b0;
        end else begin
            regwrite_q  <= regwrite_d;
            resultsrc_q <= resultsrc_d;
            rd_q        <= rd_d;
            pcplus4_q   <= pcplus4_d;
            alu_q       <= alu_d;
            rdata_q     <= rdata_d;
            misalign_q  <= misalign_d;
        end
    end

    assign RegWriteW   = regwrite_q;
    assign ResultSrcW  = resultsrc_q;
    assign RD_W        = rd_q;
    assign PCPlus4W    = pcplus4_q;
    assign ALU_ResultW = alu_q;
    assign ReadDataW   = rdata_q;
    assign MisalignW   = misalign_q;

endmodule

// File: doc/memory_cycle.md
Name: memory_cycle

Overview:
- MEM stage of the 5-stage RV32I pipeline, directly upstream of the writeback stage.
- Performs data-memory loads and stores (byte/half/word, with sign/zero extension) and holds the MEM/WB pipeline register.
- Registered outputs drive the writeback stage inputs ResultSrcW, PCPlus4W, ALU_ResultW and ReadDataW, plus RegWriteW and RD_W for the register file and hazard unit.

Parameters:
DEPTH, 1024, data-memory size in 32-bit words; must be a power of 2.
AW, $clog2(DEPTH), word-index width.

Ports:
clk  in  1  pipeline clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
RegWriteM  in  1  register-file write enable of the instruction in MEM.
ResultSrcM  in  2  result select: 00 ALU, 01 load data, 10 PC+4.
MemWriteM  in  1  store enable.
MemReadM  in  1  load enable.
funct3M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
RD_M  in  5  destination register.
PCPlus4M  in  32  PC+4 of the MEM instruction.
ALU_ResultM  in  32  effective address, or ALU result.
WriteDataM  in  32  store data (rs2).
stallW  in  1  hold the MEM/WB register.
flushW  in  1  insert a bubble into the MEM/WB register.
RegWriteW  out  1  registered RegWriteM, forced 0 on misalign or flush.
ResultSrcW  out  2  registered ResultSrcM.
RD_W  out  5  registered RD_M.
PCPlus4W  out  32  registered PCPlus4M.
ALU_ResultW  out  32  registered ALU_ResultM.
ReadDataW  out  32  registered, extended load data.
MisalignW  out  1  registered misaligned-access flag.

Behaviour:
- Reset (rst=0, asynchronous): all W outputs go to 0 immediately and stay 0 while rst is low. Memory contents are not reset.
- Address mapping:
  - word index = ALU_ResultM[AW+1:2]; higher address bits are ignored, so addresses alias modulo 4*DEPTH.
  - byte lane = ALU_ResultM[1:0].
- Misalignment: H/HU with addr[0]=1, or W with addr[1:0]≠00.
  - A misaligned store is suppressed; memory is unchanged.
  - A misaligned load or store sets MisalignW=1 and forces RegWriteW=0 in the next cycle.
- Store:
  - Written at the rising edge when MemWriteM=1, the access is aligned and rst=1.
  - Byte enables: B writes lane addr[1:0] with WriteDataM[7:0]; H writes lanes {addr[1],0} and {addr[1],1} with WriteDataM[15:0]; W writes all 4 lanes.
  - Stores are independent of stallW and flushW. A stalled store rewrites the same value, which is idempotent.
- Load:
  - Memory read is combinational from the current address.
  - Selected byte/half is sign-extended (B, H) or zero-extended (BU, HU), then registered into ReadDataW.
  - Latency: 1 cycle from MEM to W.
  - When MemReadM=0, ReadDataW still captures the extended read value; the writeback mux ignores it.
- Store then load: a store in cycle N followed by a load of the same address in cycle N+1 returns the new data, because the read is asynchronous and the write happens at the edge.
- Same-cycle read and write: impossible from one instruction. If MemReadM=MemWriteM=1, the store is performed and ReadDataW returns the pre-store data.
- MEM/WB register update priority on each edge:
  - flushW=1: RegWriteW=0, MisalignW=0, ResultSrcW=00, RD_W=0; the other outputs take the incoming values.
  - else stallW=1: all W outputs hold.
  - else: all W outputs load the MEM values.
  - flushW wins when flushW and stallW are both high.
- Invalid funct3 (011, 11x): treated as W for both size and alignment checks.

Decomposition:
- Shared package riscv_pkg:
  - RESULT_ALU=2'b00, RESULT_MEM=2'b01, RESULT_PC4=2'b10.
  - F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - XLEN=32.
- One sub-module, data_memory:
  - DEPTH words with a byte-enable write port and a combinational read port.
  - No reset on the array.
- memory_cycle contains:
  - byte-enable and store-data lane alignment;
  - load extraction and extension;
  - misalignment detection;
  - the MEM/WB register.

Test Plan:
1. Reset: hold rst=0 with random M inputs -> all W outputs 0. Release rst and apply RegWriteM=1, ResultSrcM=00, ALU_ResultM=0x3, PCPlus4M=0x2, RD_M=5 -> after 1 edge: ALU_ResultW=0x3, PCPlus4W=0x2, RD_W=5, RegWriteW=1.
2. SW 0x8040_FF7F to 0x10, then LW/LB/LBU/LH/LHU from 0x10, 0x11, 0x12 -> ReadDataW sequence:
   - LW 0x10 -> 0x8040FF7F
   - LB 0x10 -> 0x0000007F
   - LB 0x11 -> 0xFFFFFFFF
   - LBU 0x11 -> 0x000000FF
   - LH 0x12 -> 0xFFFF8040
   - LHU 0x12 -> 0x00008040
3. Partial store: SB 0xAA to 0x13 over the word from scenario 2 -> LW 0x10 = 0xAA40FF7F. SH 0x1234 to 0x10 -> LW 0x10 = 0xAA401234.
4. Misaligned: SW to 0x22 (word previously 0), then LW 0x20 -> store suppressed, LW returns 0. The SW cycle gives MisalignW=1 next cycle. A misaligned LH to 0x21 with RegWriteM=1 -> RegWriteW=0, MisalignW=1.
5. Stall/flush:
   - stallW=1 for 3 cycles while M inputs change -> W outputs hold their values.
   - flushW=1 with stallW=1 -> RegWriteW=0, RD_W=0 on the next edge.
6. Async reset mid-stream: assert rst=0 between edges after SW 0x5A to 0x40 -> W outputs go to 0 without a clock edge. Release rst, LW 0x40 -> ReadDataW=0x0000005A (memory retained).
